// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: read ports, write port and scoreboard reserve.
// The master side is the pipeline (decode/writeback); the slave side is the register file.
interface regfile_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NREAD*AW-1:0]    ReadRegister;
  logic [NREAD*WIDTH-1:0] ReadData;
  logic [NREAD-1:0]       ReadBusy;
  logic [AW-1:0]          WriteRegister;
  logic [WIDTH-1:0]       WriteData;
  logic [WIDTH/8-1:0]     ByteEnable;
  logic                   RegWrite;
  logic                   ReserveEn;
  logic [AW-1:0]          ReserveRegister;

  modport master (
    output ReadRegister, WriteRegister, WriteData, ByteEnable, RegWrite,
           ReserveEn, ReserveRegister,
    input  ReadData, ReadBusy
  );

  modport slave (
    input  ReadRegister, WriteRegister, WriteData, ByteEnable, RegWrite,
           ReserveEn, ReserveRegister,
    output ReadData, ReadBusy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised MIPS register file with byte-enabled writes, optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
module regfile_param #(
  parameter int          WIDTH    = 32,
  parameter int          DEPTH    = 32,
  parameter int          NREAD    = 2,
  parameter int          ZERO_REG = 1,
  parameter int          SP_INDEX = 29,
  parameter logic [31:0] SP_INIT  = 32'h00003ffc,
  parameter int          BYPASS   = 1
) (
  input logic            Clk,
  input logic            Reset_n,
  regfile_param_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = WIDTH / 8;
  localparam logic [WIDTH-1:0] SP_INIT_W = WIDTH'(SP_INIT);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] busy_r;

  logic             wr_en_s;
  logic             rsv_en_s;
  logic [WIDTH-1:0] merged_s;
  logic [NREAD*WIDTH-1:0] read_data_s;
  logic [NREAD-1:0]       read_busy_s;

  function automatic logic [WIDTH-1:0] merge_bytes(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] new_word,
    input logic [NB-1:0]    be
  );
    logic [WIDTH-1:0] m;
    m = old_word;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) begin
        m[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        m[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return m;
  endfunction

  // Write/reserve qualification; the hard-wired zero register absorbs both.
  always_comb begin
    wr_en_s  = bus.RegWrite;
    rsv_en_s = bus.ReserveEn;
    if (ZERO_REG != 0) begin
      if (bus.WriteRegister == {AW{1'b0}}) begin
        wr_en_s = 1'b0;
      end else begin
        wr_en_s = bus.RegWrite;
      end
      if (bus.ReserveRegister == {AW{1'b0}}) begin
        rsv_en_s = 1'b0;
      end else begin
        rsv_en_s = bus.ReserveEn;
      end
    end else begin
      wr_en_s  = bus.RegWrite;
      rsv_en_s = bus.ReserveEn;
    end
    merged_s = merge_bytes(mem_r[bus.WriteRegister], bus.WriteData, bus.ByteEnable);
  end

  // Storage and scoreboard; the reserve is applied last so it wins over a clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= (i == SP_INDEX) ? SP_INIT_W : {WIDTH{1'b0}};
      end
      busy_r <= {DEPTH{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[bus.WriteRegister]  <= merged_s;
        busy_r[bus.WriteRegister] <= 1'b0;
      end
      if (rsv_en_s) begin
        busy_r[bus.ReserveRegister] <= 1'b1;
      end
    end
  end

  // Combinational read ports with optional same-cycle bypass of the merged write.
  always_comb begin
    logic [AW-1:0] ra;
    read_data_s = {(NREAD*WIDTH){1'b0}};
    read_busy_s = {NREAD{1'b0}};
    for (int k = 0; k < NREAD; k++) begin
      ra = bus.ReadRegister[k*AW +: AW];
      if ((ZERO_REG != 0) && (ra == {AW{1'b0}})) begin
        read_data_s[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        read_busy_s[k]                = 1'b0;
      end else if ((BYPASS != 0) && wr_en_s && (ra == bus.WriteRegister)) begin
        read_data_s[k*WIDTH +: WIDTH] = merged_s;
        read_busy_s[k]                = rsv_en_s && (bus.ReserveRegister == ra);
      end else begin
        read_data_s[k*WIDTH +: WIDTH] = mem_r[ra];
        read_busy_s[k]                = busy_r[ra];
      end
    end
  end

  assign bus.ReadData = read_data_s;
  assign bus.ReadBusy = read_busy_s;
endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench: default file with bypass, a no-bypass copy and a
// narrow 16x8 three-port variant, all sharing one clock and reset.
module tb_regfile_param;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_param_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus0 ();
  regfile_param_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus1 ();
  regfile_param_if #(.WIDTH(16), .DEPTH(8),  .NREAD(3)) bus2 ();

  regfile_param #(.BYPASS(1)) dut0 (.Clk(clk), .Reset_n(rst_n), .bus(bus0));
  regfile_param #(.BYPASS(0)) dut1 (.Clk(clk), .Reset_n(rst_n), .bus(bus1));
  regfile_param #(.WIDTH(16), .DEPTH(8), .NREAD(3), .SP_INDEX(7)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [4:0] a;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus0.ReadRegister = 10'd0; bus0.WriteRegister = 5'd0; bus0.WriteData = 32'd0;
    bus0.ByteEnable = 4'd0; bus0.RegWrite = 1'b0; bus0.ReserveEn = 1'b0; bus0.ReserveRegister = 5'd0;
    bus1.ReadRegister = 10'd0; bus1.WriteRegister = 5'd0; bus1.WriteData = 32'd0;
    bus1.ByteEnable = 4'd0; bus1.RegWrite = 1'b0; bus1.ReserveEn = 1'b0; bus1.ReserveRegister = 5'd0;
    bus2.ReadRegister = 9'd0; bus2.WriteRegister = 3'd0; bus2.WriteData = 16'd0;
    bus2.ByteEnable = 2'd0; bus2.RegWrite = 1'b0; bus2.ReserveEn = 1'b0; bus2.ReserveRegister = 3'd0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset asserted mid-cycle during a write+reserve to r5
    bus0.RegWrite = 1'b1; bus0.WriteRegister = 5'd5; bus0.WriteData = 32'hDEADBEEF;
    bus0.ByteEnable = 4'hF; bus0.ReserveEn = 1'b1; bus0.ReserveRegister = 5'd5;
    #2 rst_n = 1'b0;
    @(negedge clk);
    bus0.RegWrite = 1'b0; bus0.ReserveEn = 1'b0;
    for (int r = 0; r < 32; r++) begin
      a = 5'(r);
      bus0.ReadRegister = {a, a};
      #1;
      check_val("rst_p0", {32'd0, bus0.ReadData[31:0]},  (r == 29) ? 64'h3ffc : 64'h0);
      check_val("rst_p1", {32'd0, bus0.ReadData[63:32]}, (r == 29) ? 64'h3ffc : 64'h0);
      check_val("rst_busy", {62'd0, bus0.ReadBusy}, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus0.ReadRegister = {5'd5, 5'd5};
    bus1.ReadRegister = {5'd29, 5'd29};
    bus2.ReadRegister = {3'd7, 3'd7, 3'd7};
    #1;
    check_val("r5_after_rst", {32'd0, bus0.ReadData[31:0]}, 64'h0);
    check_val("r5_busy_after_rst", {63'd0, bus0.ReadBusy[0]}, 64'h0);
    check_val("dut1_sp", {32'd0, bus1.ReadData[63:32]}, 64'h3ffc);
    check_val("dut2_sp", {48'd0, bus2.ReadData[47:32]}, 64'h3ffc);

    // byte-enabled write to r7
    @(negedge clk);
    bus0.RegWrite = 1'b1; bus0.WriteRegister = 5'd7; bus0.WriteData = 32'h11223344; bus0.ByteEnable = 4'hF;
    @(negedge clk);
    bus0.WriteData = 32'hAABBCCDD; bus0.ByteEnable = 4'b0101;
    @(negedge clk);
    bus0.RegWrite = 1'b0; bus0.ReadRegister = {5'd7, 5'd7};
    #1;
    check_val("be_p0", {32'd0, bus0.ReadData[31:0]},  64'h11BB33DD);
    check_val("be_p1", {32'd0, bus0.ReadData[63:32]}, 64'h11BB33DD);

    // zero register ignores write and reserve
    @(negedge clk);
    bus0.RegWrite = 1'b1; bus0.WriteRegister = 5'd0; bus0.WriteData = 32'hFFFFFFFF; bus0.ByteEnable = 4'hF;
    bus0.ReserveEn = 1'b1; bus0.ReserveRegister = 5'd0; bus0.ReadRegister = {5'd0, 5'd0};
    #1;
    check_val("zero_during", {bus0.ReadData}, 64'h0);
    check_val("zero_busy_during", {62'd0, bus0.ReadBusy}, 64'h0);
    @(negedge clk);
    bus0.RegWrite = 1'b0; bus0.ReserveEn = 1'b0;
    #1;
    check_val("zero_after", {bus0.ReadData}, 64'h0);
    check_val("zero_busy_after", {62'd0, bus0.ReadBusy}, 64'h0);

    // bypass on (dut0) and off (dut1) for r3
    @(negedge clk);
    bus0.RegWrite = 1'b1; bus0.WriteRegister = 5'd3; bus0.WriteData = 32'h12345678; bus0.ByteEnable = 4'hF;
    bus0.ReadRegister = {5'd7, 5'd3};
    bus1.RegWrite = 1'b1; bus1.WriteRegister = 5'd3; bus1.WriteData = 32'h12345678; bus1.ByteEnable = 4'hF;
    bus1.ReadRegister = {5'd3, 5'd3};
    #1;
    check_val("byp_pre", {32'd0, bus0.ReadData[31:0]}, 64'h12345678);
    check_val("byp_other_port", {32'd0, bus0.ReadData[63:32]}, 64'h11BB33DD);
    check_val("byp_busy", {63'd0, bus0.ReadBusy[0]}, 64'h0);
    check_val("nobyp_pre", {32'd0, bus1.ReadData[31:0]}, 64'h0);
    @(negedge clk);
    bus1.RegWrite = 1'b0;
    bus0.WriteData = 32'hAABBCCDD; bus0.ByteEnable = 4'b0011;
    #1;
    check_val("byp_partial", {32'd0, bus0.ReadData[31:0]}, 64'h1234CCDD);
    check_val("nobyp_post", {32'd0, bus1.ReadData[31:0]}, 64'h12345678);
    @(negedge clk);
    bus0.RegWrite = 1'b0;
    #1;
    check_val("byp_partial_post", {32'd0, bus0.ReadData[31:0]}, 64'h1234CCDD);

    // scoreboard on r9
    bus0.ReadRegister = {5'd9, 5'd9};
    bus0.ReserveEn = 1'b1; bus0.ReserveRegister = 5'd9;
    #1;
    check_val("sb_pre_reserve", {63'd0, bus0.ReadBusy[1]}, 64'h0);
    @(negedge clk);
    bus0.ReserveEn = 1'b0;
    #1;
    check_val("sb_reserved", {63'd0, bus0.ReadBusy[1]}, 64'h1);
    @(negedge clk);
    bus0.ReserveEn = 1'b1;
    @(negedge clk);
    bus0.ReserveEn = 1'b0;
    #1;
    check_val("sb_rereserve", {63'd0, bus0.ReadBusy[1]}, 64'h1);
    bus0.RegWrite = 1'b1; bus0.WriteRegister = 5'd9; bus0.WriteData = 32'h00000099; bus0.ByteEnable = 4'hF;
    #1;
    check_val("sb_write_byp_busy", {62'd0, bus0.ReadBusy}, 64'h0);
    @(negedge clk);
    bus0.RegWrite = 1'b0;
    #1;
    check_val("sb_cleared", {62'd0, bus0.ReadBusy}, 64'h0);
    check_val("sb_data", {32'd0, bus0.ReadData[31:0]}, 64'h99);
    bus0.RegWrite = 1'b1; bus0.ReserveEn = 1'b1; bus0.ReserveRegister = 5'd9;
    #1;
    check_val("sb_both_byp_busy", {63'd0, bus0.ReadBusy[0]}, 64'h1);
    @(negedge clk);
    bus0.RegWrite = 1'b0; bus0.ReserveEn = 1'b0;
    #1;
    check_val("sb_set_wins", {62'd0, bus0.ReadBusy}, 64'h3);

    // narrow variant: partial write to r1, three ports concurrently
    @(negedge clk);
    bus2.ReadRegister = {3'd7, 3'd1, 3'd1};
    #1;
    check_val("n_r1_init", {48'd0, bus2.ReadData[15:0]}, 64'h0);
    bus2.RegWrite = 1'b1; bus2.WriteRegister = 3'd1; bus2.WriteData = 16'hBEEF; bus2.ByteEnable = 2'b10;
    @(negedge clk);
    bus2.RegWrite = 1'b0;
    #1;
    check_val("n_p0", {48'd0, bus2.ReadData[15:0]},  64'hBE00);
    check_val("n_p1", {48'd0, bus2.ReadData[31:16]}, 64'hBE00);
    check_val("n_p2", {48'd0, bus2.ReadData[47:32]}, 64'h3ffc);
    check_val("n_busy", {61'd0, bus2.ReadBusy}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
